// File: rtl/mem_rd_arbiter.sv
// ============================================================================
// Module      : mem_rd_arbiter
// Description : Read arbiter that shares a single-port, 1-cycle-latency memory
//               between the instruction-fetch (IF) and data-load (DM) masters.
//               DM has fixed priority over IF. A starvation guard forces an IF
//               grant after STARVE_MAX consecutive denied cycles.
//               Out-of-range addresses are granted but never issued to memory.
//               They are answered with an error response instead.
//               Optional feature macro: MEM_ARB_STATS_EN (adds grant counters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_rd_arbiter #(
  parameter int MEM_WORDS  = 256,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // Instruction-fetch master
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  output logic             if_rerr,
  // Data-load master
  input  logic             dm_req,
  input  logic [31:0]      dm_addr,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [31:0]      dm_rdata,
  output logic             dm_rerr,
  // Memory side
  output logic [31:0]      mem_addr,
  output logic             mem_r_enable,
  input  logic [31:0]      mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] if_gnt_cnt,
  output logic [CNT_W-1:0] dm_gnt_cnt
`endif
);

  // Word-index limit and starvation threshold sized to the signals they meet.
  localparam logic [29:0] C_MEM_WORDS  = 30'(MEM_WORDS);
  localparam logic [3:0]  C_STARVE_MAX = 4'(STARVE_MAX);

  // Which master the response in the next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  owner_t      r_rsp_owner;
  owner_t      w_rsp_owner_nxt;
  logic        r_rsp_err;
  logic        w_rsp_err_nxt;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_cnt_nxt;

  logic        w_force_if;
  logic        w_dm_win;
  logic        w_if_win;
  logic        w_any_win;
  logic [31:0] w_win_addr;
  logic        w_win_oor;
  logic        w_issue;

  // Arbitration: DM first unless IF has been starved long enough.
  // All grants are masked while reset is asserted.
  always_comb begin
    w_force_if = 1'b0;
    w_dm_win   = 1'b0;
    w_if_win   = 1'b0;
    w_any_win  = 1'b0;
    w_win_addr = '0;
    w_win_oor  = 1'b0;
    w_issue    = 1'b0;

    w_force_if = if_req && (r_starve_cnt == C_STARVE_MAX);
    w_dm_win   = rst_n && dm_req && !w_force_if;
    w_if_win   = rst_n && if_req && !w_dm_win;
    w_any_win  = w_dm_win || w_if_win;
    w_win_addr = w_dm_win ? dm_addr : if_addr;
    w_win_oor  = (w_win_addr[31:2] >= C_MEM_WORDS);
    w_issue    = w_any_win && !w_win_oor;
  end

  // Next-state: response ownership, error flag and saturating starvation count.
  always_comb begin
    w_rsp_owner_nxt  = OWN_NONE;
    w_rsp_err_nxt    = 1'b0;
    w_starve_cnt_nxt = '0;

    if (w_dm_win) begin
      w_rsp_owner_nxt = OWN_DM;
    end else if (w_if_win) begin
      w_rsp_owner_nxt = OWN_IF;
    end

    w_rsp_err_nxt = w_any_win && w_win_oor;

    if (if_req && !w_if_win) begin
      if (r_starve_cnt < C_STARVE_MAX) begin
        w_starve_cnt_nxt = r_starve_cnt + 4'd1;
      end else begin
        w_starve_cnt_nxt = C_STARVE_MAX;
      end
    end
  end

  // State registers; an in-flight response is discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_owner  <= OWN_NONE;
      r_rsp_err    <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_rsp_owner  <= w_rsp_owner_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  // Output decode: grants, memory issue and the one-cycle-late response.
  always_comb begin
    if_gnt       = 1'b0;
    dm_gnt       = 1'b0;
    mem_r_enable = 1'b0;
    mem_addr     = '0;
    if_rvalid    = 1'b0;
    if_rerr      = 1'b0;
    if_rdata     = '0;
    dm_rvalid    = 1'b0;
    dm_rerr      = 1'b0;
    dm_rdata     = '0;

    if_gnt       = w_if_win;
    dm_gnt       = w_dm_win;
    mem_r_enable = w_issue;
    if (w_issue) begin
      mem_addr = w_win_addr;
    end

    if (rst_n && (r_rsp_owner == OWN_IF)) begin
      if_rvalid = 1'b1;
      if_rerr   = r_rsp_err;
      if (!r_rsp_err) begin
        if_rdata = mem_rdata;
      end
    end

    if (rst_n && (r_rsp_owner == OWN_DM)) begin
      dm_rvalid = 1'b1;
      dm_rerr   = r_rsp_err;
      if (!r_rsp_err) begin
        dm_rdata = mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] r_if_gnt_cnt;
  logic [CNT_W-1:0] r_dm_gnt_cnt;

  // Free-running grant counters, error grants included, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_gnt_cnt <= '0;
      r_dm_gnt_cnt <= '0;
    end else begin
      if (w_if_win) begin
        r_if_gnt_cnt <= r_if_gnt_cnt + CNT_W'(1);
      end
      if (w_dm_win) begin
        r_dm_gnt_cnt <= r_dm_gnt_cnt + CNT_W'(1);
      end
    end
  end

  assign if_gnt_cnt = r_if_gnt_cnt;
  assign dm_gnt_cnt = r_dm_gnt_cnt;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_rd_arbiter.sv
// ============================================================================
// Module      : tb_mem_rd_arbiter
// Description : Self-checking bench for mem_rd_arbiter with a behavioural
//               memory and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_rd_arbiter;

  localparam int MEM_WORDS  = 256;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 16;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        if_req  = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req  = 1'b0;
  logic [31:0] dm_addr = '0;
  logic        if_gnt, if_rvalid, if_rerr;
  logic [31:0] if_rdata;
  logic        dm_gnt, dm_rvalid, dm_rerr;
  logic [31:0] dm_rdata;
  logic [31:0] mem_addr;
  logic        mem_r_enable;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] if_gnt_cnt, dm_gnt_cnt;
`endif

  logic [31:0] mem [MEM_WORDS];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_denied  = 0;
  bit          m_rv_if   = 1'b0;
  bit          m_rv_dm   = 1'b0;
  bit          m_err     = 1'b0;
  logic [31:0] m_data    = '0;
  int          m_if_cnt  = 0;
  int          m_dm_cnt  = 0;
  bit          obs_if_gnt;
  bit          obs_dm_gnt;

  mem_rd_arbiter #(
    .MEM_WORDS (MEM_WORDS),
    .STARVE_MAX(STARVE_MAX),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .if_rerr     (if_rerr),
    .dm_req      (dm_req),
    .dm_addr     (dm_addr),
    .dm_gnt      (dm_gnt),
    .dm_rvalid   (dm_rvalid),
    .dm_rdata    (dm_rdata),
    .dm_rerr     (dm_rerr),
    .mem_addr    (mem_addr),
    .mem_r_enable(mem_r_enable),
    .mem_rdata   (mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .if_gnt_cnt  (if_gnt_cnt),
    .dm_gnt_cnt  (dm_gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory: 1-cycle read latency; garbage on the bus when not read.
  always @(posedge clk) begin
    if (mem_r_enable) mem_rdata <= mem[mem_addr[9:2]];
    else              mem_rdata <= $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_denied = 0;
    m_rv_if  = 1'b0;
    m_rv_dm  = 1'b0;
    m_err    = 1'b0;
    m_data   = '0;
    m_if_cnt = 0;
    m_dm_cnt = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom | 32'h0000_0400;
    return ($urandom_range(0, MEM_WORDS - 1) << 2) | ($urandom & 32'd3);
  endfunction

  // One clock cycle: inputs are already applied; checks at the falling edge,
  // then the model advances and the task returns just after the next rise.
  task automatic step(output bit gi, output bit gd);
    logic [31:0] a;
    bit e_if, e_dm, any, oor, iss;
    @(negedge clk);
    e_dm = dm_req && !(if_req && m_denied >= STARVE_MAX);
    e_if = if_req && !e_dm;
    any  = e_if || e_dm;
    a    = e_dm ? dm_addr : if_addr;
    oor  = (a / 4) >= MEM_WORDS;
    iss  = any && !oor;
    chk("if_gnt",       if_gnt,       e_if);
    chk("dm_gnt",       dm_gnt,       e_dm);
    chk("mem_r_enable", mem_r_enable, iss);
    chk("mem_addr",     mem_addr,     iss ? a : 32'd0);
    chk("if_rvalid",    if_rvalid,    m_rv_if);
    chk("if_rdata",     if_rdata,     (m_rv_if && !m_err) ? m_data : 32'd0);
    chk("if_rerr",      if_rerr,      m_rv_if && m_err);
    chk("dm_rvalid",    dm_rvalid,    m_rv_dm);
    chk("dm_rdata",     dm_rdata,     (m_rv_dm && !m_err) ? m_data : 32'd0);
    chk("dm_rerr",      dm_rerr,      m_rv_dm && m_err);
`ifdef MEM_ARB_STATS_EN
    chk("if_gnt_cnt",   if_gnt_cnt,   m_if_cnt % (1 << CNT_W));
    chk("dm_gnt_cnt",   dm_gnt_cnt,   m_dm_cnt % (1 << CNT_W));
`endif
    obs_if_gnt = if_gnt;
    obs_dm_gnt = dm_gnt;
    m_rv_if = e_if;
    m_rv_dm = e_dm;
    m_err   = oor;
    m_data  = oor ? 32'd0 : mem[a[9:2]];
    if (e_if) m_if_cnt++;
    if (e_dm) m_dm_cnt++;
    if (if_req && !e_if) m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : STARVE_MAX;
    else                 m_denied = 0;
    gi = e_if;
    gd = e_dm;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},     {if_gnt, dm_gnt}, 2'b00);
    chk({tag, "_rsp"},     {if_rvalid, dm_rvalid, if_rerr, dm_rerr}, 4'b0000);
    chk({tag, "_mem_en"},  mem_r_enable, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_rdata"},   {if_rdata, dm_rdata}, 64'd0);
`ifdef MEM_ARB_STATS_EN
    chk({tag, "_cnt"},     {if_gnt_cnt, dm_gnt_cnt}, '0);
`endif
  endtask

  initial begin
    bit gi, gd;
    bit pend_if, pend_dm;
    logic [9:0] pat_if, pat_dm;

    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[100] = 32'h0403_0201;
    mem[101] = 32'h0807_0605;

    // Reset state, with a request present to show grants are masked
    dm_req  = 1'b1;
    dm_addr = 32'h10;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    check_reset_outputs("reset_neg");
    dm_req = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Single IF read
    if_req = 1'b1; if_addr = 32'h190;
    step(gi, gd);
    if_req = 1'b0;
    step(gi, gd);

    // Contention: DM wins, IF holds and is served next
    if_req = 1'b1; if_addr = 32'h190;
    dm_req = 1'b1; dm_addr = 32'h194;
    step(gi, gd);
    chk("cont_dm_first", {obs_dm_gnt, obs_if_gnt}, 2'b10);
    dm_req = 1'b0;
    step(gi, gd);
    chk("cont_if_second", {obs_dm_gnt, obs_if_gnt}, 2'b01);
    if_req = 1'b0;
    step(gi, gd);

    // Starvation: DM held for 10 cycles, IF forced through on cycle 5
    if_req = 1'b1; if_addr = 32'h190;
    dm_req = 1'b1;
    pat_if = '0;
    pat_dm = '0;
    for (int i = 0; i < 10; i++) begin
      dm_addr = ($urandom_range(0, MEM_WORDS - 1) << 2);
      step(gi, gd);
      pat_if[i] = obs_if_gnt;
      pat_dm[i] = obs_dm_gnt;
      if (gi) if_req = 1'b0;
    end
    chk("starve_if_pattern", pat_if, 10'b00000_10000);
    chk("starve_dm_pattern", pat_dm, 10'b11111_01111);
    dm_req = 1'b0;
    step(gi, gd);

    // Out of range DM read, then the last legal and first illegal IF words
    dm_req = 1'b1; dm_addr = 32'h400;
    step(gi, gd);
    dm_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h3FF;
    step(gi, gd);
    if_addr = 32'h400;
    step(gi, gd);
    if_req = 1'b0;
    step(gi, gd);

    // Back-to-back alternating IF/DM for 8 cycles
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        if_req = 1'b1; if_addr = ($urandom_range(0, MEM_WORDS - 1) << 2); dm_req = 1'b0;
      end else begin
        dm_req = 1'b1; dm_addr = ($urandom_range(0, MEM_WORDS - 1) << 2); if_req = 1'b0;
      end
      step(gi, gd);
    end
    if_req = 1'b0; dm_req = 1'b0;
    step(gi, gd);

    // Reset while an IF response is in flight
    if_req = 1'b1; if_addr = 32'h190;
    step(gi, gd);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    check_reset_outputs("rst_mid_neg");
    @(posedge clk);
    #1;
    if_req = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    step(gi, gd);

    // Randomized traffic obeying the hold-until-granted rule
    pend_if = 1'b0;
    pend_dm = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!pend_if) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = rand_addr();
      end
      if (!pend_dm) begin
        dm_req  = ($urandom_range(0, 99) < 55);
        dm_addr = rand_addr();
      end
      step(gi, gd);
      pend_if = if_req && !gi;
      pend_dm = dm_req && !gd;
    end
    if_req = 1'b0; dm_req = 1'b0;
    step(gi, gd);
    step(gi, gd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
